// File: rtl/poly_wave_pkg.sv
// poly_wave_pkg: shared constants for the polyphonic wave generator.
// Mode codes, note range, base pitch table and the phase-increment function.
package poly_wave_pkg;

  localparam logic [1:0] MODE_SQUARE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_MUTE   = 2'd3;

  localparam logic [7:0] NOTE_LO = 8'h18;
  localparam logic [7:0] NOTE_HI = 8'h6B;

  localparam longint unsigned CLK_HZ = 100_000_000;

  // C..B of the reference octave (notes 0x3C..0x47), entry 0 is C.
  localparam logic [11:0][8:0] BASE_HZ = {
    9'd494, 9'd466, 9'd440, 9'd415,
    9'd392, 9'd370, 9'd349, 9'd330,
    9'd311, 9'd294, 9'd277, 9'd262
  };

  // Elaboration-time only. NOTE_LO is three octaves under the reference,
  // so the 2^-3 is folded into the divisor to keep everything integral.
  function automatic logic [63:0] inc_of(
    input logic [7:0] note,
    input int         acc_w
  );
    int          idx;
    int          oct;
    logic [3:0]  semi;
    logic [63:0] num;
    idx  = int'(note) - int'(NOTE_LO);
    oct  = idx / 12;
    semi = 4'(idx % 12);
    num  = 64'(BASE_HZ[semi]) << (acc_w + oct);
    return (num + 64'(4 * CLK_HZ)) / 64'(8 * CLK_HZ);
  endfunction

endpackage

// File: rtl/poly_wave_gen_voice.sv
// wave_voice: one voice - phase accumulator, stored note, waveform shaper.
// In: clk, reset, mode, load/clear/kill, load_note. Out: active, note_q, sample.
module wave_voice
  import poly_wave_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic             clear,
  input  logic             kill,
  input  logic [7:0]       load_note,
  output logic             active,
  output logic [7:0]       note_q,
  output logic [OUT_W-1:0] sample
);

  localparam int NUM_NOTES =
    int'(NOTE_HI) - int'(NOTE_LO) + 1;

  function automatic logic [NUM_NOTES-1:0][ACC_W-1:0]
    build_rom();
    logic [NUM_NOTES-1:0][ACC_W-1:0] rom;
    for (int i = 0; i < NUM_NOTES; i++)
      rom[i] = ACC_W'(inc_of(
        8'(int'(NOTE_LO) + i), ACC_W));
    return rom;
  endfunction

  localparam logic [NUM_NOTES-1:0][ACC_W-1:0]
    INC_ROM = build_rom();

  logic [ACC_W-1:0] phase;
  logic [ACC_W-1:0] inc_q;
  logic [6:0]       rom_idx;

  assign rom_idx = 7'(load_note - NOTE_LO);

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      phase  <= '0;
      note_q <= '0;
      inc_q  <= '0;
    end else if (kill) begin
      active <= 1'b0;
      phase  <= '0;
    end else if (load) begin
      active <= 1'b1;
      phase  <= '0;
      note_q <= load_note;
      inc_q  <= INC_ROM[rom_idx];
    end else if (clear) begin
      active <= 1'b0;
      phase  <= '0;
    end else if (active) begin
      phase <= phase + inc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample <= '0;
    end else begin
      unique case (mode)
        MODE_SQUARE:
          sample <= {OUT_W{phase[ACC_W-1]}};
        MODE_SAW:
          sample <= phase[ACC_W-1 -: OUT_W];
        MODE_TRI:
          sample <= phase[ACC_W-1]
            ? ~phase[ACC_W-2 -: OUT_W]
            :  phase[ACC_W-2 -: OUT_W];
        MODE_MUTE:
          sample <= '0;
      endcase
    end
  end

endmodule

// File: rtl/poly_wave_gen.sv
// poly_wave_gen: polyphonic oscillator bank with voice allocation/stealing,
// volume-scaled mix and sigma-delta pwm. Ports: note events in, mask/mix/pwm out.
module poly_wave_gen
  import poly_wave_pkg::*;
#(
  parameter  int NUM_VOICES = 4,
  parameter  int ACC_W      = 32,
  parameter  int OUT_W      = 10,
  localparam int SUM_W      = OUT_W + $clog2(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  on_off,
  input  logic [7:0]            note,
  input  logic                  all_off,
  input  logic [1:0]            mode,
  input  logic [3:0]            volume,
  output logic [NUM_VOICES-1:0] active_mask,
  output logic                  steal,
  output logic [SUM_W-1:0]      mix,
  output logic                  pwm
);

  localparam int PTR_W =
    NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;

  logic [NUM_VOICES-1:0]            active;
  logic [NUM_VOICES-1:0]            hit;
  logic [NUM_VOICES-1:0]            load;
  logic [NUM_VOICES-1:0]            clear;
  logic [NUM_VOICES-1:0]            free_sel;
  logic [NUM_VOICES-1:0][7:0]       note_q;
  logic [NUM_VOICES-1:0][OUT_W-1:0] sample;
  logic [PTR_W-1:0]                 steal_ptr;
  logic                             fire;
  logic                             in_range;
  logic                             found;
  logic                             do_steal;
  logic [SUM_W-1:0]                 sum;
  logic [SUM_W+3:0]                 scaled;
  logic [SUM_W-1:0]                 sd_acc;
  logic [SUM_W:0]                   sd_next;

  assign in_ready    = ~reset & ~all_off;
  assign fire        = in_valid & in_ready;
  assign in_range    = (note >= NOTE_LO) &&
                       (note <= NOTE_HI);
  assign active_mask = active;

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++)
      hit[i] = active[i] && (note_q[i] == note);
  end

  always_comb begin
    free_sel = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!active[i] && !found) begin
        free_sel[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // A held note retriggers in place, so a note is never in two voices.
  always_comb begin
    load     = '0;
    clear    = '0;
    do_steal = 1'b0;
    if (fire && on_off && in_range) begin
      priority case (1'b1)
        |hit:  load = hit;
        found: load = free_sel;
        default: begin
          load[steal_ptr] = 1'b1;
          do_steal        = 1'b1;
        end
      endcase
    end
    if (fire && !on_off)
      clear = hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      steal_ptr <= '0;
      steal     <= 1'b0;
    end else begin
      steal <= do_steal;
      if (do_steal)
        steal_ptr <=
          (steal_ptr == PTR_W'(NUM_VOICES - 1))
          ? '0 : steal_ptr + PTR_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    wave_voice #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
    ) u_voice (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode),
      .load      (load[g]),
      .clear     (clear[g]),
      .kill      (all_off),
      .load_note (note),
      .active    (active[g]),
      .note_q    (note_q[g]),
      .sample    (sample[g])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      sum = sum + SUM_W'(sample[i]);
  end

  assign scaled  = (SUM_W+4)'(sum) *
                   (SUM_W+4)'(volume);
  assign sd_next = {1'b0, sd_acc} + {1'b0, mix};

  always_ff @(posedge clk) begin
    if (reset) begin
      mix    <= '0;
      sd_acc <= '0;
      pwm    <= 1'b0;
    end else begin
      mix    <= scaled[SUM_W+3:4];
      sd_acc <= sd_next[SUM_W-1:0];
      pwm    <= sd_next[SUM_W];
    end
  end

endmodule

// File: tb/tb_poly_wave_gen.sv
// tb_poly_wave_gen: directed stimulus with a per-cycle behavioural model
// and hand-computed spot checks for poly_wave_gen.
module tb_poly_wave_gen;

  localparam int NV  = 4;
  localparam int SW  = 12;
  localparam longint unsigned WRAP = 64'h1_0000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          on_off;
  logic [7:0]    note;
  logic          all_off;
  logic [1:0]    mode;
  logic [3:0]    volume;
  logic [NV-1:0] active_mask;
  logic          steal;
  logic [SW-1:0] mix;
  logic          pwm;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  poly_wave_gen #(
    .NUM_VOICES (NV),
    .ACC_W      (32),
    .OUT_W      (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .on_off      (on_off),
    .note        (note),
    .all_off     (all_off),
    .mode        (mode),
    .volume      (volume),
    .active_mask (active_mask),
    .steal       (steal),
    .mix         (mix),
    .pwm         (pwm)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned model_inc(
    input logic [7:0] n
  );
    int  hz [12];
    int  k;
    int  semi;
    real f;
    hz = '{262, 277, 294, 311, 330, 349,
           370, 392, 415, 440, 466, 494};
    semi = (int'(n) - 24) % 12;
    k    = (int'(n) - 24) / 12 - 3;
    f    = real'(hz[semi]) * (2.0 ** k);
    return longint'($rtoi(
      f * (2.0 ** 32) / 1.0e8 + 0.5));
  endfunction

  function automatic int shape(
    input longint unsigned p,
    input logic [1:0] m
  );
    int t;
    bit hi;
    hi = (p >= 64'h8000_0000);
    t  = int'((p >> 21) % 1024);
    case (m)
      2'd0:    return hi ? 1023 : 0;
      2'd1:    return int'(p >> 22);
      2'd2:    return hi ? 1023 - t : t;
      default: return 0;
    endcase
  endfunction

  bit               m_act  [NV];
  logic [7:0]       m_note [NV];
  longint unsigned  m_ph   [NV];
  int               m_samp [NV];
  int               m_mix;
  int               m_acc;
  bit               m_pwm;
  bit               m_steal;
  int               m_sp;

  always @(posedge clk) begin : model
    automatic bit              a  [NV] = m_act;
    automatic logic [7:0]      nn [NV] = m_note;
    automatic longint unsigned ph [NV] = m_ph;
    automatic int              sp  = m_sp;
    automatic bit              stl = 1'b0;
    automatic int              s   = 0;
    automatic int              fr  = -1;
    automatic bit              held = 1'b0;
    if (reset) begin
      for (int i = 0; i < NV; i++) begin
        m_act[i]  <= 1'b0;
        m_note[i] <= 8'h00;
        m_ph[i]   <= 0;
        m_samp[i] <= 0;
      end
      m_mix   <= 0;
      m_acc   <= 0;
      m_pwm   <= 1'b0;
      m_steal <= 1'b0;
      m_sp    <= 0;
    end else begin
      for (int i = 0; i < NV; i++) s += m_samp[i];
      m_mix <= (s * int'(volume)) / 16;
      m_pwm <= (m_acc + m_mix) >= 4096;
      m_acc <= (m_acc + m_mix) % 4096;
      for (int i = 0; i < NV; i++)
        m_samp[i] <= shape(m_ph[i], mode);
      if (all_off) begin
        for (int i = 0; i < NV; i++) begin
          a[i]  = 1'b0;
          ph[i] = 0;
        end
      end else begin
        for (int i = 0; i < NV; i++)
          if (a[i]) ph[i] = (ph[i] + model_inc(nn[i])) % WRAP;
        if (in_valid && on_off &&
            note >= 8'h18 && note <= 8'h6B) begin
          for (int i = 0; i < NV; i++)
            if (a[i] && nn[i] == note) begin
              ph[i] = 0;
              held  = 1'b1;
            end
          if (!held) begin
            for (int i = NV - 1; i >= 0; i--)
              if (!a[i]) fr = i;
            if (fr < 0) begin
              fr  = sp;
              stl = 1'b1;
              sp  = (sp + 1) % NV;
            end
            a[fr]  = 1'b1;
            nn[fr] = note;
            ph[fr] = 0;
          end
        end else if (in_valid && !on_off) begin
          for (int i = 0; i < NV; i++)
            if (a[i] && nn[i] == note) begin
              a[i]  = 1'b0;
              ph[i] = 0;
            end
        end
      end
      m_act   <= a;
      m_note  <= nn;
      m_ph    <= ph;
      m_sp    <= sp;
      m_steal <= stl;
    end
  end

  task automatic chk(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      automatic logic [NV-1:0] em;
      for (int i = 0; i < NV; i++) em[i] = m_act[i];
      chk("cyc active_mask", 32'(active_mask), 32'(em));
      chk("cyc steal", 32'(steal), 32'(m_steal));
      chk("cyc mix", 32'(mix), 32'(m_mix));
      chk("cyc pwm", 32'(pwm), 32'(m_pwm));
      chk("cyc in_ready", 32'(in_ready),
          32'(!reset && !all_off));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input bit on, input logic [7:0] n);
    in_valid = 1'b1;
    on_off   = on;
    note     = n;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic panic();
    all_off = 1'b1;
    #1;
    chk("panic in_ready", 32'(in_ready), 32'd0);
    tick();
    all_off = 1'b0;
    chk("panic mask", 32'(active_mask), 32'd0);
  endtask

  initial begin
    int ones;
    reset    = 1'b1;
    in_valid = 1'b0;
    on_off   = 1'b0;
    note     = 8'h00;
    all_off  = 1'b0;
    mode     = 2'd1;
    volume   = 4'd15;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst mask", 32'(active_mask), 32'd0);
    chk("rst mix", 32'(mix), 32'd0);
    chk("rst pwm", 32'(pwm), 32'd0);
    chk("rst steal", 32'(steal), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("inc 0x45", 32'(model_inc(8'h45)), 32'd18898);
    chk("inc 0x3C", 32'(model_inc(8'h3C)), 32'd11253);
    reset = 1'b0;
    tick();

    ev(1'b1, 8'h45);
    chk("first on", 32'(active_mask), 32'b0001);
    repeat (300) tick();
    panic();

    ev(1'b1, 8'h3C);
    ev(1'b1, 8'h3D);
    ev(1'b1, 8'h3E);
    ev(1'b1, 8'h3F);
    chk("fill 4", 32'(active_mask), 32'b1111);
    ev(1'b1, 8'h40);
    chk("steal pulse", 32'(steal), 32'd1);
    chk("steal mask", 32'(active_mask), 32'b1111);
    tick();
    chk("steal once", 32'(steal), 32'd0);

    ev(1'b0, 8'h3E);
    chk("off 3E", 32'(active_mask), 32'b1011);
    ev(1'b0, 8'h3E);
    chk("off 3E again", 32'(active_mask), 32'b1011);
    ev(1'b1, 8'h3D);
    chk("retrigger", 32'(active_mask), 32'b1011);
    chk("retrig no steal", 32'(steal), 32'd0);
    ev(1'b1, 8'h10);
    chk("out of range", 32'(active_mask), 32'b1011);

    ev(1'b1, 8'h41);
    chk("refill", 32'(active_mask), 32'b1111);
    ev(1'b1, 8'h42);
    chk("steal ptr 1", 32'(steal), 32'd1);
    ev(1'b0, 8'h3D);
    chk("stolen 3D gone", 32'(active_mask), 32'b1111);
    ev(1'b0, 8'h40);
    chk("v0 held 40", 32'(active_mask), 32'b1110);
    ev(1'b0, 8'h42);
    chk("v1 held 42", 32'(active_mask), 32'b1100);

    ev(1'b1, 8'h6B);
    mode = 2'd2;
    repeat (2000) tick();
    mode = 2'd0;
    repeat (500) tick();
    mode = 2'd1;

    ev(1'b1, 8'h50);
    chk("full again", 32'(active_mask), 32'b1111);
    repeat (500) tick();
    panic();
    tick();
    tick();
    chk("panic mix", 32'(mix), 32'd0);

    ev(1'b1, 8'h3C);
    ev(1'b1, 8'h3D);
    ev(1'b1, 8'h3E);
    ev(1'b1, 8'h3F);
    repeat (50) tick();
    reset    = 1'b1;
    in_valid = 1'b1;
    on_off   = 1'b1;
    note     = 8'h55;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("reset mask", 32'(active_mask), 32'd0);
    chk("reset mix", 32'(mix), 32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("reset drop", 32'(active_mask), 32'd0);

    mode   = 2'd0;
    volume = 4'd8;
    ev(1'b1, 8'h6B);
    for (int i = 0; i < 20000 && m_mix != 511; i++)
      tick();
    chk("square mix 511", 32'(mix), 32'd511);
    ones = 0;
    repeat (4096) begin
      tick();
      ones += int'(pwm);
    end
    chk("pwm duty 511", 32'(ones), 32'd511);

    volume = 4'd0;
    tick();
    tick();
    ones = 0;
    repeat (20) begin
      tick();
      ones += int'(pwm);
    end
    chk("vol0 pwm", 32'(ones), 32'd0);
    chk("vol0 mix", 32'(mix), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/poly_wave_gen.md
POLY_WAVE_GEN -- requirements
Module: poly_wave_gen

Interface
REQ-001 Parameter NUM_VOICES, default 4, number of simultaneous voices (1..16).
REQ-002 Parameter ACC_W, default 32, phase-accumulator width in bits.
REQ-003 Parameter OUT_W, default 10, per-voice sample width in bits.
REQ-004 Derived width SUM_W = OUT_W + clog2(NUM_VOICES).
REQ-005 Clock and reset ports: one clock, clk; reset is synchronous and active-high, port reset.
REQ-006 Port list (name, direction, width, meaning):
- clk, in, 1, system clock, 100 MHz.
- reset, in, 1, synchronous active-high reset.
- in_valid, in, 1, note event present.
- in_ready, out, 1, event accepted when in_valid and in_ready are both high.
- on_off, in, 1, 1 = note-on, 0 = note-off.
- note, in, 8, MIDI note number.
- all_off, in, 1, panic: release every voice.
- mode, in, 2, waveform select: 0 square, 1 sawtooth, 2 triangle, 3 mute.
- volume, in, 4, master gain 0..15.
- active_mask, out, NUM_VOICES, per-voice active flag.
- steal, out, 1, one-cycle pulse when a voice is stolen.
- mix, out, SUM_W, scaled sum of voice samples.
- pwm, out, 1, first-order sigma-delta output.

Function
REQ-007 in_ready is 1 in every cycle except while reset is high and while all_off is high.
REQ-008 Valid notes are 0x18..0x6B; a note-on outside this range is accepted and ignored.
REQ-009 Note-on, note already held by an active voice: retrigger that voice (phase = 0); no new allocation.
REQ-010 Note-on, free voice exists: allocate the lowest-index free voice; it is active from cycle N+1 for acceptance in cycle N.
REQ-011 Note-on, all voices active: steal the voice at steal_ptr; load the new note, set phase to 0, pulse steal for one cycle, then steal_ptr = (steal_ptr+1) mod NUM_VOICES.
REQ-012 Note-off: deactivate every voice holding that note in cycle N+1; a note-off for a non-held note has no effect.
REQ-013 all_off high: every voice is inactive and its phase is 0 from the next cycle; steal_ptr is unchanged.
REQ-014 Active voice: each cycle phase += inc(note), modulo 2^ACC_W.
REQ-015 inc(note) = round(f(note) * 2^ACC_W / 100e6). f is 262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466 or 494 Hz for semitones C..B of octave 0x3C..0x47, scaled by 2^k per octave.
REQ-016 Inactive voice: phase is held at 0 and its sample is 0.
REQ-017 Voice sample, registered, with p = phase:
- saw = p[ACC_W-1 -: OUT_W].
- square = all-ones if p[ACC_W-1] is 1, else 0.
- triangle = p[ACC_W-2 -: OUT_W] when p[ACC_W-1] is 0, else its bitwise inverse.
- mute = 0.
REQ-018 A mode change applies to all voices in the next sample; phase is not disturbed.
REQ-019 mix = (sum of voice samples * volume) >> 4, registered. Latency from phase to mix is 2 cycles. The sum never overflows SUM_W.
REQ-020 pwm: acc_next = acc[SUM_W-1:0] + mix using SUM_W+1 bits; pwm is the registered carry bit acc_next[SUM_W]. Long-run duty = mix / 2^SUM_W.

Reset
REQ-021 On reset, all of the following are 0: active_mask, steal, mix, pwm, every phase, every stored note, steal_ptr, and the sigma-delta accumulator.
REQ-022 Reset asserted mid-note aborts all voices; any in_valid present during reset is dropped.

Structure
REQ-023 Shared package poly_wave_pkg holds the following; the per-note increment is computed from constants, with no runtime divider:
- the mode encoding constants;
- the 12-entry base frequency table;
- the note-range limits;
- the inc() function.
REQ-024 One sub-module, wave_voice, holds the phase accumulator, the stored note and the waveform shaper. It is instanced NUM_VOICES times by a generate loop; allocation, mixing and the sigma-delta stage live in the top level.

Verification
REQ-025 Setup: NUM_VOICES=4, ACC_W=32, mode=1, volume=15.
- Note-on 0x45 -> active_mask=0001 next cycle.
- Phase step 18898 per cycle.
- Saw wraps after about 227273 cycles.
REQ-026 Note-ons 0x3C, 0x3D, 0x3E, 0x3F, 0x40 on consecutive cycles:
- After the fourth, active_mask=1111.
- The fifth steals voice 0: steal pulses once, voice 0 holds 0x40, steal_ptr=1.
REQ-027 Voices filled as in REQ-026, then note-off 0x3E -> active_mask=1011; a second note-off 0x3E -> no change.
REQ-028 Retrigger and range check:
- Note-on 0x3C while already held -> no allocation, that voice's phase=0.
- Note-on 0x10 -> accepted, active_mask unchanged.
REQ-029 Output scaling:
- Mode=0, one voice at phase MSB=1, volume=8 -> mix=511.
- Volume=0 -> mix=0 and pwm stays 0.
- Constant mix=2048 (SUM_W=12) -> pwm duty exactly 50%.
REQ-030 Reset and panic:
- all_off pulse, or reset, with 4 voices active -> next cycle active_mask=0000 and in_ready low during the pulse.
- mix=0 two cycles later.
